seven_segment_scan_driver: RTL and testbench
============================================

// Module: seven_segment_scan_driver
// PURPOSE
//  Parametrised multi-digit hex seven-segment driver. Latches a packed NUM_DIGITS-nibble value,
//  time-multiplexes one shared segment bus across NUM_DIGITS common-enable digits, and decodes
//  each nibble to 0-9/A-F glyphs. Adds decimal points, leading-zero blanking, polarity options and
//  a frame tick. Sits between the display datapath and the board segment/digit pins.
// PARAMETERS
//  NUM_DIGITS        2      digits scanned, 1..8
//  CLKS_PER_DIGIT    25000  clocks each digit is held enabled (1 ms at 25 MHz), >= 2
//  SEG_ACTIVE_LOW    1      1: segment lit = 0 (including DP); 0: lit = 1
//  DIG_ACTIVE_LOW    0      1: digit enabled = 0; 0: enabled = 1
//  BLANK_LEADING     0      1: suppress leading zero digits
// PORTS
//  i_Clk          in   1              system clock
//  i_Rst          in   1              reset, asynchronous, active-high
//  i_Value        in   4*NUM_DIGITS   packed nibbles; digit k = i_Value[4k+3:4k], digit 0 = LS
//  i_DP           in   NUM_DIGITS     decimal point per digit, 1 = lit
//  i_Load         in   1              capture i_Value/i_DP into shadow regs on this edge
//  o_Segments     out  7              {A,B,C,D,E,F,G}, A = bit 6, registered
//  o_Segment_DP   out  1              decimal point of active digit, registered
//  o_Digit_En     out  NUM_DIGITS     one-hot digit enable, registered
//  o_Frame_Tick   out  1              1-cycle pulse when scan wraps to digit 0
// BEHAVIOUR
//  - Reset (async assert): tick counter = 0, digit index = 0, shadow value/DP = 0, segments and
//    DP off per SEG_ACTIVE_LOW, all digits disabled per DIG_ACTIVE_LOW, o_Frame_Tick = 0.
//  - Shadow: i_Load = 1 at edge t updates shadow at t; outputs reflect it at edge t+1. Held inputs
//    without i_Load are ignored, so no mid-frame tearing. i_Load may be held high.
//  - Scan: counter 0..CLKS_PER_DIGIT-1 then wraps to 0. On wrap, index advances k -> k+1, and
//    NUM_DIGITS-1 -> 0. NUM_DIGITS = 1: index stays 0 and the counter still runs.
//  - Outputs are registered from (index, shadow) with 1-clock latency. The first edge after reset
//    release enables digit 0. Exactly one digit is enabled at any time after that.
//  - o_Frame_Tick = 1 for the single cycle in which outputs first show digit 0 after digit
//    NUM_DIGITS-1. There is no pulse at the first post-reset frame.
//  - Decode, active-high form (inverted if SEG_ACTIVE_LOW): 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F
//    7:70 8:7F 9:7B A:77 b:1F C:4E d:3D E:4F F:47.
//  - Blanking (BLANK_LEADING = 1): digit k (k > 0) is blank if shadow nibbles k..NUM_DIGITS-1 are
//    all 0. Digit 0 is never blanked. A blank digit has all 7 segments off and its enable still
//    scans. DP follows i_DP even when the digit is blank.
//  - Reset mid-scan: all outputs return to reset values immediately (async). The scan restarts at
//    digit 0 with counter 0.
//  - Counter width = $clog2(CLKS_PER_DIGIT). Index width = $clog2(NUM_DIGITS), min 1.
// TESTING
//  - NUM_DIGITS=2, CLKS_PER_DIGIT=4, active-low segs: reset -> o_Segments=7F, o_Digit_En=00, then
//    digit 0 shows 0 (o_Segments=01).
//  - Load 8'h3A, DP=2'b10 -> digit0 o_Segments=~77=08, DP off. Digit1 o_Segments=~79=06, DP lit.
//    Each digit is held 4 clocks.
//  - Scan 4 digits, CLKS_PER_DIGIT=3: o_Digit_En cycles 0001,0010,0100,1000,0001.
//    o_Frame_Tick pulses once per 12 clocks, on the 1000->0001 transition only.
//  - BLANK_LEADING=1, 4 digits, load 16'h0050: digits 3,2 blank, digit1 = '5', digit0 = '0'.
//    Load 16'h0000: only digit0 lit, showing '0'.
//  - Change i_Value without i_Load for a full frame -> display unchanged. Pulse i_Load -> new value
//    shows 1 clock later.
//  - Assert i_Rst asynchronously mid-digit 2 -> outputs go to reset values without a clock edge.
//    After release the scan resumes at digit 0.

Source files
------------

// File: rtl/seven_segment_scan_driver.sv
// seven_segment_scan_driver
//   Multi-digit hex seven-segment scan driver. A packed value of NUM_DIGITS nibbles and
//   per-digit decimal points are captured into shadow registers on i_Load. A single segment
//   bus is time-multiplexed across NUM_DIGITS common-enable digits, each held for
//   CLKS_PER_DIGIT clocks. Optional leading-zero blanking and output polarity selection.
//
// Ports
//   i_Clk         system clock
//   i_Rst         asynchronous active-high reset
//   i_Value       packed nibbles, digit k = i_Value[4k+3:4k], digit 0 least significant
//   i_DP          decimal point per digit, 1 = lit
//   i_Load        capture i_Value/i_DP into the shadow registers on this edge
//   o_Segments    {A,B,C,D,E,F,G}, A = bit 6, registered
//   o_Segment_DP  decimal point of the active digit, registered
//   o_Digit_En    one-hot digit enable, registered
//   o_Frame_Tick  one-cycle pulse when the displayed digit wraps back to digit 0
module seven_segment_scan_driver #(
  parameter int unsigned NUM_DIGITS     = 2,
  parameter int unsigned CLKS_PER_DIGIT = 25000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b0,
  parameter bit          BLANK_LEADING  = 1'b0
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic [4*NUM_DIGITS-1:0] i_Value,
  input  logic [NUM_DIGITS-1:0]   i_DP,
  input  logic                    i_Load,
  output logic [6:0]              o_Segments,
  output logic                    o_Segment_DP,
  output logic [NUM_DIGITS-1:0]   o_Digit_En,
  output logic                    o_Frame_Tick
);

  localparam int unsigned CntW = $clog2(CLKS_PER_DIGIT);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CntW-1:0]       CntMax = CntW'(CLKS_PER_DIGIT - 1);
  localparam logic [IdxW-1:0]       IdxMax = IdxW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SegOff = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DpOff  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] DigOff = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  // Active-high glyph for one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] g;
    unique case (nib)
      4'h0:    g = 7'h7E;
      4'h1:    g = 7'h30;
      4'h2:    g = 7'h6D;
      4'h3:    g = 7'h79;
      4'h4:    g = 7'h33;
      4'h5:    g = 7'h5B;
      4'h6:    g = 7'h5F;
      4'h7:    g = 7'h70;
      4'h8:    g = 7'h7F;
      4'h9:    g = 7'h7B;
      4'hA:    g = 7'h77;
      4'hB:    g = 7'h1F;
      4'hC:    g = 7'h4E;
      4'hD:    g = 7'h3D;
      4'hE:    g = 7'h4F;
      4'hF:    g = 7'h47;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  // Set on the edge the index wraps to 0; turns into the tick as digit 0 reaches the pins.
  logic                    wrap_q, wrap_d;
  logic [6:0]              seg_q, seg_d;
  logic                    seg_dp_q, seg_dp_d;
  logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                    tick_q;

  logic                    cnt_wrap;
  logic [3:0]              nibble;
  logic                    dp_sel;
  logic                    blank_sel;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic [6:0]              seg_on;
  logic [NUM_DIGITS-1:0]   onehot;

  // Scan timing.
  always_comb begin
    cnt_wrap = (cnt_q == CntMax);
    cnt_d    = cnt_wrap ? '0 : cnt_q + CntW'(1);
    idx_d    = idx_q;
    wrap_d   = 1'b0;
    if (cnt_wrap) begin
      if (idx_q == IdxMax) begin
        idx_d  = '0;
        wrap_d = 1'b1;
      end else begin
        idx_d  = idx_q + IdxW'(1);
      end
    end
  end

  // Digit select, leading-zero detection and decode.
  always_comb begin
    nibble    = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    zero_run  = 1'b1;
    blank_vec = '0;
    // Walk from the most significant digit down; a digit is blank while everything
    // from it upward is zero. Digit 0 is never blanked.
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (value_q[4*k +: 4] == 4'h0);
      if (k > 0) begin
        blank_vec[k] = zero_run;
      end
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IdxW'(k)) begin
        nibble    = value_q[4*k +: 4];
        dp_sel    = dp_q[k];
        blank_sel = BLANK_LEADING & blank_vec[k];
      end
    end
    seg_on   = blank_sel ? 7'h00 : decode(nibble);
    seg_d    = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
    seg_dp_d = SEG_ACTIVE_LOW ? ~dp_sel : dp_sel;
    onehot   = NUM_DIGITS'(1) << idx_q;
    dig_en_d = DIG_ACTIVE_LOW ? ~onehot : onehot;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      value_q  <= '0;
      dp_q     <= '0;
      wrap_q   <= 1'b0;
      seg_q    <= SegOff;
      seg_dp_q <= DpOff;
      dig_en_q <= DigOff;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wrap_q   <= wrap_d;
      seg_q    <= seg_d;
      seg_dp_q <= seg_dp_d;
      dig_en_q <= dig_en_d;
      tick_q   <= wrap_q;
      if (i_Load) begin
        value_q <= i_Value;
        dp_q    <= i_DP;
      end
    end
  end

  assign o_Segments   = seg_q;
  assign o_Segment_DP = seg_dp_q;
  assign o_Digit_En   = dig_en_q;
  assign o_Frame_Tick = tick_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
module tb_seven_segment_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // DUT A: 4 digits, 3 clocks per digit, leading-zero blanking.
  logic [15:0] val_a = '0;
  logic [3:0]  dp_a = '0;
  logic        load_a = 1'b0;
  logic [6:0]  seg_a;
  logic        sdp_a;
  logic [3:0]  en_a;
  logic        tick_a;

  // DUT B: 2 digits, 4 clocks per digit, no blanking.
  logic [7:0]  val_b = '0;
  logic [1:0]  dp_b = '0;
  logic        load_b = 1'b0;
  logic [6:0]  seg_b;
  logic        sdp_b;
  logic [1:0]  en_b;
  logic        tick_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seven_segment_scan_driver #(
    .NUM_DIGITS(4), .CLKS_PER_DIGIT(3), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b0),
    .BLANK_LEADING(1'b1)
  ) u_dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_Value(val_a), .i_DP(dp_a), .i_Load(load_a),
    .o_Segments(seg_a), .o_Segment_DP(sdp_a), .o_Digit_En(en_a), .o_Frame_Tick(tick_a)
  );

  seven_segment_scan_driver #(
    .NUM_DIGITS(2), .CLKS_PER_DIGIT(4), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b0),
    .BLANK_LEADING(1'b0)
  ) u_dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Value(val_b), .i_DP(dp_b), .i_Load(load_b),
    .o_Segments(seg_b), .o_Segment_DP(sdp_b), .o_Digit_En(en_b), .o_Frame_Tick(tick_b)
  );

  // Reference model: edges since reset release plus the shadow contents as they stood
  // before the most recent edge (what the outputs were computed from).
  int          e_a = 0, e_b = 0;
  logic [15:0] sh_a = '0, shp_a = '0;
  logic [3:0]  dsh_a = '0, dshp_a = '0;
  logic [7:0]  sh_b = '0, shp_b = '0;
  logic [1:0]  dsh_b = '0, dshp_b = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_a <= 0; sh_a <= '0; shp_a <= '0; dsh_a <= '0; dshp_a <= '0;
      e_b <= 0; sh_b <= '0; shp_b <= '0; dsh_b <= '0; dshp_b <= '0;
    end else begin
      e_a <= e_a + 1; shp_a <= sh_a; dshp_a <= dsh_a;
      e_b <= e_b + 1; shp_b <= sh_b; dshp_b <= dsh_b;
      if (load_a) begin sh_a <= val_a; dsh_a <= dp_a; end
      if (load_b) begin sh_b <= val_b; dsh_b <= dp_b; end
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    return tbl[n];
  endfunction

  // Compare one DUT against the time-based model (segments active low, digits active high).
  task automatic check_dut(input string tag, input int e, input int clks, input int n,
                           input bit blank, input logic [31:0] shv, input logic [7:0] dpv,
                           input logic [6:0] seg, input logic dp, input logic [7:0] en,
                           input logic tick);
    int         d;
    logic [6:0] x_seg;
    logic       x_dp;
    logic [7:0] x_en;
    logic       x_tick;
    logic [31:0] upper;
    if (e == 0) begin
      x_seg = 7'h7F; x_dp = 1'b1; x_en = 8'h00; x_tick = 1'b0;
    end else begin
      d      = ((e - 1) / clks) % n;
      upper  = shv >> (4 * d);
      x_en   = 8'd1 << d;
      x_dp   = ~dpv[d];
      x_tick = (e > 1) && (((e - 1) % (clks * n)) == 0);
      x_seg  = (blank && d > 0 && upper == 0) ? 7'h7F : ~glyph(upper[3:0]);
    end
    checks += 4;
    assert (seg === x_seg) else begin
      failures++; $error("FAIL %s_seg e=%0d got=%h exp=%h", tag, e, seg, x_seg);
    end
    assert (dp === x_dp) else begin
      failures++; $error("FAIL %s_dp e=%0d got=%b exp=%b", tag, e, dp, x_dp);
    end
    assert (en === x_en) else begin
      failures++; $error("FAIL %s_en e=%0d got=%b exp=%b", tag, e, en, x_en);
    end
    assert (tick === x_tick) else begin
      failures++; $error("FAIL %s_tick e=%0d got=%b exp=%b", tag, e, tick, x_tick);
    end
  endtask

  task automatic check_both();
    check_dut("a", e_a, 3, 4, 1'b1, {16'h0, shp_a}, {4'h0, dshp_a}, seg_a, sdp_a,
              {4'h0, en_a}, tick_a);
    check_dut("b", e_b, 4, 2, 1'b0, {24'h0, shp_b}, {6'h0, dshp_b}, seg_b, sdp_b,
              {6'h0, en_b}, tick_b);
  endtask

  // Run cycles, checking at every falling edge; inputs stay as set.
  task automatic run_checked(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_both();
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks += 4;
    assert (seg_a === 7'h7F && seg_b === 7'h7F) else begin
      failures++; $error("FAIL %s_seg got=%h/%h exp=7f/7f", tag, seg_a, seg_b);
    end
    assert (sdp_a === 1'b1 && sdp_b === 1'b1) else begin
      failures++; $error("FAIL %s_dp got=%b/%b exp=1/1", tag, sdp_a, sdp_b);
    end
    assert (en_a === 4'b0000 && en_b === 2'b00) else begin
      failures++; $error("FAIL %s_en got=%b/%b exp=0000/00", tag, en_a, en_b);
    end
    assert (tick_a === 1'b0 && tick_b === 1'b0) else begin
      failures++; $error("FAIL %s_tick got=%b/%b exp=0/0", tag, tick_a, tick_b);
    end
  endtask

  initial begin
    int found;
    int ticks;

    // Reset state.
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    check_both();
    rst = 1'b0;

    // First edge after release: digit 0 showing '0'.
    @(negedge clk);
    checks++;
    assert (seg_b === 7'h01 && en_b === 2'b01) else begin
      failures++; $error("FAIL first_digit got=%h/%b exp=01/01", seg_b, en_b);
    end
    check_both();
    run_checked(12);

    // Directed loads: B = 3A with DP on digit 1, A = 0050 (blanking of digits 3 and 2).
    val_b = 8'h3A; dp_b = 2'b10; load_b = 1'b1;
    val_a = 16'h0050; dp_a = 4'b0100; load_a = 1'b1;
    run_checked(1);
    load_a = 1'b0; load_b = 1'b0;
    run_checked(24);
    val_a = 16'h0000; dp_a = 4'b0000; load_a = 1'b1;
    run_checked(1);
    load_a = 1'b0;
    run_checked(24);

    // Inputs change without load for a full frame: display must not follow.
    val_a = 16'hBEEF; dp_a = 4'b1111; val_b = 8'hC4; dp_b = 2'b11;
    run_checked(16);
    load_a = 1'b1; load_b = 1'b1;
    run_checked(1);
    load_a = 1'b0; load_b = 1'b0;
    run_checked(12);

    // Frame tick count over exactly four frames of DUT A.
    ticks = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      check_both();
      if (tick_a === 1'b1) ticks++;
    end
    checks++;
    assert (ticks == 4) else begin
      failures++; $error("FAIL tick_count got=%0d exp=4", ticks);
    end

    // Randomized loads, including load held high for stretches.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      check_both();
      val_a  = 16'($urandom);
      if ($urandom_range(3) == 0) val_a = val_a & 16'h00FF;
      if ($urandom_range(3) == 0) val_a = 16'h0;
      dp_a   = 4'($urandom);
      load_a = ($urandom_range(5) == 0) || (i >= 200 && i < 230);
      val_b  = 8'($urandom);
      dp_b   = 2'($urandom);
      load_b = ($urandom_range(5) == 0);
    end
    load_a = 1'b0; load_b = 1'b0;

    // Asynchronous reset in the middle of digit 2 of DUT A.
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      check_both();
      if (en_a === 4'b0100) found = 1;
    end
    checks++;
    assert (found == 1) else begin
      failures++; $error("FAIL wait_digit2 got=%0d exp=1", found);
    end
    #2 rst = 1'b1;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    check_both();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    assert (en_a === 4'b0001 && seg_a === 7'h01) else begin
      failures++; $error("FAIL resume got=%b/%h exp=0001/01", en_a, seg_a);
    end
    check_both();
    run_checked(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
